// File: rtl/rob_tagged.sv
`default_nettype none
// ============================================================================
// Module   : rob_tagged
// Purpose  : Tag-addressed circular reorder buffer with in-order commit and
//            flush on jump-target mismatch. Optional macro ROB_WB_BYPASS_EN
//            lets a writeback to the head tag commit in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module rob_tagged #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int RD_W   = 5,
  parameter int NUM_WB = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [PC_W-1:0]          disp_pc,
  input  logic [RD_W-1:0]          disp_rd,
  output logic [TAG_W-1:0]         disp_tag,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*TAG_W-1:0]  wb_tag,
  input  logic [NUM_WB*DATA_W-1:0] wb_data,
  input  logic [NUM_WB*PC_W-1:0]   wb_jpc,
  output logic                     commit_valid,
  output logic [TAG_W-1:0]         commit_tag,
  output logic [PC_W-1:0]          commit_pc,
  output logic [RD_W-1:0]          commit_rd,
  output logic [DATA_W-1:0]        commit_data,
  output logic                     flush,
  output logic [PC_W-1:0]          flush_pc,
  output logic [TAG_W:0]           count,
  output logic                     empty
);

  localparam logic [PC_W-1:0] C_PC_STEP = PC_W'(4);
  localparam logic [TAG_W:0]  C_FULL    = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W-1:0] C_TAG_ONE = TAG_W'(1);

  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_done;
  logic [PC_W-1:0]   r_pc   [DEPTH];
  logic [PC_W-1:0]   r_jpc  [DEPTH];
  logic [RD_W-1:0]   r_rd   [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [TAG_W-1:0]  r_head;
  logic [TAG_W-1:0]  r_tail;
  logic [TAG_W:0]    r_count;

  logic [TAG_W-1:0]  w_wb_tag  [NUM_WB];
  logic [DATA_W-1:0] w_wb_data [NUM_WB];
  logic [PC_W-1:0]   w_wb_jpc  [NUM_WB];
  logic [NUM_WB-1:0] w_wb_hit;

  logic              w_commit;
  logic              w_mispredict;
  logic              w_disp;
  logic [DATA_W-1:0] w_c_data;
  logic [PC_W-1:0]   w_c_jpc;
  logic [PC_W-1:0]   w_head_seq_pc;

  // Writebacks landing in the flush cycle belong to discarded instructions.
  for (genvar k = 0; k < NUM_WB; k++) begin : g_wb_unpack
    assign w_wb_tag[k]  = wb_tag[k*TAG_W +: TAG_W];
    assign w_wb_data[k] = wb_data[k*DATA_W +: DATA_W];
    assign w_wb_jpc[k]  = wb_jpc[k*PC_W +: PC_W];
    assign w_wb_hit[k]  = wb_valid[k] & r_valid[w_wb_tag[k]] & ~flush;
  end

`ifdef ROB_WB_BYPASS_EN
  logic              w_head_hit;
  logic [DATA_W-1:0] w_hh_data;
  logic [PC_W-1:0]   w_hh_jpc;

  // Descending scan: the lowest-index channel is assigned last and wins.
  always_comb begin
    w_head_hit = 1'b0;
    w_hh_data  = '0;
    w_hh_jpc   = '0;
    for (int k = NUM_WB-1; k >= 0; k--) begin
      if (w_wb_hit[k] && (w_wb_tag[k] == r_head)) begin
        w_head_hit = 1'b1;
        w_hh_data  = w_wb_data[k];
        w_hh_jpc   = w_wb_jpc[k];
      end
    end
  end

  always_comb begin
    w_commit = r_valid[r_head] & (r_done[r_head] | w_head_hit);
    w_c_data = r_done[r_head] ? r_data[r_head] : w_hh_data;
    w_c_jpc  = r_done[r_head] ? r_jpc[r_head]  : w_hh_jpc;
  end
`else
  assign w_commit = r_valid[r_head] & r_done[r_head];
  assign w_c_data = r_data[r_head];
  assign w_c_jpc  = r_jpc[r_head];
`endif

  assign w_head_seq_pc = r_pc[r_head] + C_PC_STEP;
  assign w_mispredict  = w_commit & (w_c_jpc != w_head_seq_pc);

  assign disp_ready = (r_count < C_FULL) & ~flush;
  assign disp_tag   = r_tail;
  assign w_disp     = disp_valid & disp_ready & ~w_mispredict;
  assign count      = r_count;
  assign empty      = (r_count == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid      <= '0;
      r_done       <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      commit_valid <= 1'b0;
      commit_tag   <= '0;
      commit_pc    <= '0;
      commit_rd    <= '0;
      commit_data  <= '0;
      flush        <= 1'b0;
      flush_pc     <= '0;
    end else begin
      commit_valid <= w_commit;
      flush        <= w_mispredict;
      if (w_commit) begin
        commit_tag  <= r_head;
        commit_pc   <= r_pc[r_head];
        commit_rd   <= r_rd[r_head];
        commit_data <= w_c_data;
      end
      for (int k = 0; k < NUM_WB; k++) begin
        if (w_wb_hit[k]) r_done[w_wb_tag[k]] <= 1'b1;
      end
      if (w_mispredict) begin
        flush_pc <= w_c_jpc;
        r_valid  <= '0;
        r_done   <= '0;
        r_head   <= '0;
        r_tail   <= '0;
        r_count  <= '0;
      end else begin
        if (w_commit) begin
          r_valid[r_head] <= 1'b0;
          r_head          <= r_head + C_TAG_ONE;
        end
        if (w_disp) begin
          r_valid[r_tail] <= 1'b1;
          r_done[r_tail]  <= 1'b0;
          r_tail          <= r_tail + C_TAG_ONE;
        end
        case ({w_disp, w_commit})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // The tail slot is never valid while a dispatch is accepted, so dispatch
  // and writeback never target the same entry in one cycle.
  always_ff @(posedge clk) begin
    for (int k = NUM_WB-1; k >= 0; k--) begin
      if (w_wb_hit[k]) begin
        r_data[w_wb_tag[k]] <= w_wb_data[k];
        r_jpc[w_wb_tag[k]]  <= w_wb_jpc[k];
      end
    end
    if (w_disp) begin
      r_pc[r_tail]  <= disp_pc;
      r_rd[r_tail]  <= disp_rd;
      r_jpc[r_tail] <= disp_pc + C_PC_STEP;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rob_tagged.sv
`default_nettype none
// ============================================================================
// Module   : tb_rob_tagged
// Purpose  : Self-checking bench for rob_tagged: queue-based reference model,
//            directed scenarios with literal expectations, randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rob_tagged;

  localparam int DEPTH  = 16;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int RD_W   = 5;
  localparam int NUM_WB = 2;
`ifdef ROB_WB_BYPASS_EN
  localparam int C_WB_TO_COMMIT = 1;
`else
  localparam int C_WB_TO_COMMIT = 2;
`endif

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     disp_valid;
  logic                     disp_ready;
  logic [PC_W-1:0]          disp_pc;
  logic [RD_W-1:0]          disp_rd;
  logic [TAG_W-1:0]         disp_tag;
  logic [NUM_WB-1:0]        wb_valid;
  logic [NUM_WB*TAG_W-1:0]  wb_tag;
  logic [NUM_WB*DATA_W-1:0] wb_data;
  logic [NUM_WB*PC_W-1:0]   wb_jpc;
  logic                     commit_valid;
  logic [TAG_W-1:0]         commit_tag;
  logic [PC_W-1:0]          commit_pc;
  logic [RD_W-1:0]          commit_rd;
  logic [DATA_W-1:0]        commit_data;
  logic                     flush;
  logic [PC_W-1:0]          flush_pc;
  logic [TAG_W:0]           count;
  logic                     empty;

  always #5 clk = ~clk;

  rob_tagged #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W),
    .PC_W(PC_W), .RD_W(RD_W), .NUM_WB(NUM_WB)
  ) u_dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_pc(disp_pc),
    .disp_rd(disp_rd), .disp_tag(disp_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .wb_jpc(wb_jpc),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_pc(commit_pc),
    .commit_rd(commit_rd), .commit_data(commit_data),
    .flush(flush), .flush_pc(flush_pc), .count(count), .empty(empty)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 50)
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: ordered queue of in-flight entries ----
  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [PC_W-1:0]   pc;
    logic [RD_W-1:0]   rd;
    bit                done;
    logic [DATA_W-1:0] data;
    logic [PC_W-1:0]   jpc;
  } ent_t;

  ent_t              q[$];
  logic [TAG_W-1:0]  m_tail    = '0;
  logic              exp_cv    = 1'b0;
  logic [TAG_W-1:0]  exp_tag   = '0;
  logic [PC_W-1:0]   exp_pc    = '0;
  logic [RD_W-1:0]   exp_rd    = '0;
  logic [DATA_W-1:0] exp_data  = '0;
  logic              exp_flush = 1'b0;
  logic [PC_W-1:0]   exp_fpc   = '0;
  int                cyc       = 0;
  int                log_tag[$];
  int                log_cyc[$];

  task automatic model_step();
    int   win[$];
    int   w;
    bit   fl;
    bit   rdy;
    bit   do_c;
    ent_t c;
    ent_t n;
    fl   = exp_flush;
    rdy  = (q.size() < DEPTH) && !fl;
    do_c = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      w = -1;
      if (!fl)
        for (int k = 0; k < NUM_WB; k++)
          if (w < 0 && wb_valid[k] && wb_tag[k*TAG_W +: TAG_W] == q[i].tag) w = k;
      win.push_back(w);
    end
    if (q.size() > 0) begin
      c = q[0];
      if (c.done) do_c = 1'b1;
      else if (C_WB_TO_COMMIT == 1 && win[0] >= 0) begin
        do_c   = 1'b1;
        c.data = wb_data[win[0]*DATA_W +: DATA_W];
        c.jpc  = wb_jpc[win[0]*PC_W +: PC_W];
      end
    end
    for (int i = 0; i < q.size(); i++)
      if (win[i] >= 0) begin
        q[i].done = 1'b1;
        q[i].data = wb_data[win[i]*DATA_W +: DATA_W];
        q[i].jpc  = wb_jpc[win[i]*PC_W +: PC_W];
      end
    if (do_c) q.delete(0);
    exp_cv = do_c;
    if (do_c) begin
      exp_tag = c.tag; exp_pc = c.pc; exp_rd = c.rd; exp_data = c.data;
    end
    exp_flush = do_c && (c.jpc != c.pc + 32'd4);
    if (exp_flush) begin
      exp_fpc = c.jpc;
      q.delete();
      m_tail = '0;
    end else if (disp_valid && rdy) begin
      n.tag = m_tail; n.pc = disp_pc; n.rd = disp_rd; n.done = 1'b0;
      n.data = '0; n.jpc = disp_pc + 32'd4;
      q.push_back(n);
      m_tail = m_tail + 1'b1;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_tail = '0; exp_cv = 1'b0; exp_tag = '0; exp_pc = '0; exp_rd = '0;
      exp_data = '0; exp_flush = 1'b0; exp_fpc = '0;
    end else begin
      model_step();
      cyc++;
    end
  end

  // Single compare process, sampled on the falling edge.
  always @(negedge clk) begin
    chk("disp_ready", disp_ready, (q.size() < DEPTH) && !exp_flush);
    chk("disp_tag", disp_tag, m_tail);
    chk("count", count, q.size());
    chk("empty", empty, q.size() == 0);
    chk("commit_valid", commit_valid, exp_cv);
    chk("commit_tag", commit_tag, exp_tag);
    chk("commit_pc", commit_pc, exp_pc);
    chk("commit_rd", commit_rd, exp_rd);
    chk("commit_data", commit_data, exp_data);
    chk("flush", flush, exp_flush);
    if (exp_flush) chk("flush_pc", flush_pc, exp_fpc);
    if (commit_valid) begin
      log_tag.push_back(int'(commit_tag));
      log_cyc.push_back(cyc);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    disp_valid = 1'b0; disp_pc = '0; disp_rd = '0;
    wb_valid = '0; wb_tag = '0; wb_data = '0; wb_jpc = '0;
  endtask

  task automatic set_wb(input int k, input logic [TAG_W-1:0] t,
                        input logic [DATA_W-1:0] d, input logic [PC_W-1:0] j);
    wb_valid[k] = 1'b1;
    wb_tag[k*TAG_W +: TAG_W]   = t;
    wb_data[k*DATA_W +: DATA_W] = d;
    wb_jpc[k*PC_W +: PC_W]     = j;
  endtask

  task automatic dispatch_n(input int n, input logic [PC_W-1:0] base);
    for (int i = 0; i < n; i++) begin
      disp_valid = 1'b1; disp_pc = base + PC_W'(4*i); disp_rd = RD_W'(i);
      @(negedge clk);
    end
    disp_valid = 1'b0;
  endtask

  // Called just after a falling edge; leaves reset released and one cycle idle.
  task automatic do_reset();
    #3 rst = 1'b0;
    #1;
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_flush", flush, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_disp_tag", disp_tag, 0);
    chk("rst_commit_pc", commit_pc, 0);
    idle_inputs();
    @(negedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
  endtask

  // Writeback already driven; hold it one edge, then wait for the commit pulse.
  task automatic wb_then_wait(output int n);
    @(negedge clk);
    wb_valid = '0;
    n = 1;
    while (!commit_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("commit_seen", commit_valid, 1);
  endtask

  task automatic drive_random(input int pd, input int pw);
    ent_t e;
    logic [TAG_W-1:0] t;
    logic [PC_W-1:0]  j;
    disp_valid = ($urandom_range(0, 99) < pd);
    disp_pc    = $urandom() & 32'hFFFF_FFFC;
    disp_rd    = RD_W'($urandom_range(0, 31));
    for (int k = 0; k < NUM_WB; k++) begin
      if (q.size() > 0 && $urandom_range(0, 9) < 9) begin
        e = q[$urandom_range(0, q.size() - 1)];
        t = e.tag;
        j = ($urandom_range(0, 19) == 0) ? ($urandom() & 32'hFFFF_FFFC) : e.pc + 32'd4;
      end else begin
        t = TAG_W'($urandom_range(0, DEPTH - 1));
        j = $urandom();
      end
      if (k == 1 && $urandom_range(0, 3) == 0) t = wb_tag[0 +: TAG_W];
      wb_valid[k] = ($urandom_range(0, 99) < pw);
      wb_tag[k*TAG_W +: TAG_W]    = t;
      wb_data[k*DATA_W +: DATA_W] = $urandom();
      wb_jpc[k*PC_W +: PC_W]      = j;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int base;
    int pd_tab[8] = '{70, 90, 95, 50, 80, 30, 90, 60};
    int pw_tab[8] = '{50, 5,  10, 80, 30, 60, 20, 40};
    idle_inputs();
    repeat (2) @(negedge clk);
    #3 rst = 1'b1;
    @(negedge clk);

    // Reset state
    chk("init_count", count, 0);
    chk("init_empty", empty, 1);
    chk("init_ready", disp_ready, 1);
    chk("init_tag", disp_tag, 0);
    chk("init_cv", commit_valid, 0);
    chk("init_flush", flush, 0);

    // Single dispatch, writeback, commit
    disp_valid = 1'b1; disp_pc = 32'h100; disp_rd = 5'd3;
    #1 chk("t1_disp_tag", disp_tag, 0);
    @(negedge clk);
    disp_valid = 1'b0;
    chk("t1_count", count, 1);
    set_wb(0, 4'd0, 32'h55, 32'h104);
    wb_then_wait(n);
    chk("t1_latency", n, C_WB_TO_COMMIT);
    chk("t1_pc", commit_pc, 32'h100);
    chk("t1_rd", commit_rd, 3);
    chk("t1_data", commit_data, 32'h55);
    chk("t1_count0", count, 0);
    chk("t1_flush", flush, 0);

    // Fill to DEPTH, hold a 17th request, wrap tail after one commit
    do_reset();
    dispatch_n(16, 32'h200);
    chk("t2_full_count", count, 16);
    chk("t2_full_ready", disp_ready, 0);
    disp_valid = 1'b1; disp_pc = 32'h300; disp_rd = 5'd7;
    @(negedge clk);
    chk("t2_held_count", count, 16);
    chk("t2_held_tag", disp_tag, 0);
    set_wb(0, 4'd0, 32'h1000, 32'h204);
    wb_then_wait(n);
    chk("t2_commit_tag", commit_tag, 0);
    chk("t2_count15", count, 15);
    chk("t2_ready", disp_ready, 1);
    chk("t2_wrap_tag", disp_tag, 0);
    @(negedge clk);
    disp_valid = 1'b0;
    chk("t2_refill", count, 16);
    chk("t2_tail1", disp_tag, 1);

    // Out-of-order completion 2,0,1 commits in order 0,1,2
    do_reset();
    dispatch_n(3, 32'h100);
    base = log_tag.size();
    set_wb(0, 4'd2, 32'h22, 32'h10C); @(negedge clk);
    set_wb(0, 4'd0, 32'h20, 32'h104); @(negedge clk);
    set_wb(0, 4'd1, 32'h21, 32'h108); @(negedge clk);
    wb_valid = '0;
    repeat (4) @(negedge clk);
    chk("t3_n_commits", log_tag.size() - base, 3);
    if (log_tag.size() >= base + 3) begin
      for (int i = 0; i < 3; i++) chk("t3_order", log_tag[base+i], i);
      chk("t3_consecutive", log_cyc[base+2] - log_cyc[base], 2);
    end

    // Same-tag writeback on both channels: channel 0 wins
    do_reset();
    dispatch_n(1, 32'h100);
    set_wb(0, 4'd0, 32'hAA, 32'h104);
    set_wb(1, 4'd0, 32'hBB, 32'h104);
    wb_then_wait(n);
    chk("t4_data", commit_data, 32'hAA);

    // Mispredict flush, stale writeback during flush cycle ignored
    do_reset();
    dispatch_n(3, 32'h100);
    set_wb(0, 4'd0, 32'h1, 32'h200);
    wb_then_wait(n);
    chk("t5_flush", flush, 1);
    chk("t5_flush_pc", flush_pc, 32'h200);
    chk("t5_commit_pc", commit_pc, 32'h100);
    chk("t5_count", count, 0);
    chk("t5_empty", empty, 1);
    chk("t5_ready", disp_ready, 0);
    set_wb(0, 4'd1, 32'h77, 32'h108);
    disp_valid = 1'b1; disp_pc = 32'h400;
    @(negedge clk);
    idle_inputs();
    chk("t5_flush_off", flush, 0);
    chk("t5_count_after", count, 0);
    chk("t5_no_commit", commit_valid, 0);
    @(negedge clk);
    chk("t5_no_commit2", commit_valid, 0);

    // Asynchronous reset mid-stream with 5 entries and a live commit pulse
    do_reset();
    dispatch_n(6, 32'h100);
    set_wb(0, 4'd0, 32'h5, 32'h104);
    wb_then_wait(n);
    chk("t6_count5", count, 5);
    do_reset();
    chk("t6_count_after", count, 0);
    chk("t6_tag_after", disp_tag, 0);

    // Randomized traffic in segments of varying dispatch/writeback pressure
    for (int seg = 0; seg < 8; seg++) begin
      for (int c = 0; c < 500; c++) begin
        if ($urandom_range(0, 999) == 0) do_reset();
        drive_random(pd_tab[seg], pw_tab[seg]);
        @(negedge clk);
      end
    end
    idle_inputs();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end, %0d checks, %0d errors", n_checks, n_err);
    $fatal(1);
  end

endmodule
`default_nettype wire
